// File: rtl/alu_decoder_pkg.sv
// Shared types and constants for the alu_decoder slice.
// Holds the ALU operation enum, the comparison condition codes, the
// supported bytecode opcodes and the packed control-field struct that the
// bytecode decoder hands to the top level.
package alu_decoder_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_MUL  = 4'd2,
    ALU_DIV  = 4'd3,
    ALU_REM  = 4'd4,
    ALU_NEG  = 4'd5,
    ALU_SHL  = 4'd6,
    ALU_SHR  = 4'd7,
    ALU_USHR = 4'd8,
    ALU_AND  = 4'd9,
    ALU_OR   = 4'd10,
    ALU_XOR  = 4'd11
  } aluop_e;

  localparam logic [2:0] CMP_EQ = 3'd0;
  localparam logic [2:0] CMP_NE = 3'd1;
  localparam logic [2:0] CMP_LT = 3'd2;
  localparam logic [2:0] CMP_GE = 3'd3;
  localparam logic [2:0] CMP_GT = 3'd4;
  localparam logic [2:0] CMP_LE = 3'd5;

  localparam logic [7:0] OP_NOP       = 8'h00;
  localparam logic [7:0] OP_ICONST_M1 = 8'h02;
  localparam logic [7:0] OP_ICONST_5  = 8'h08;
  localparam logic [7:0] OP_BIPUSH    = 8'h10;
  localparam logic [7:0] OP_SIPUSH    = 8'h11;
  localparam logic [7:0] OP_IADD      = 8'h60;
  localparam logic [7:0] OP_ISUB      = 8'h64;
  localparam logic [7:0] OP_IMUL      = 8'h68;
  localparam logic [7:0] OP_IDIV      = 8'h6C;
  localparam logic [7:0] OP_IREM      = 8'h70;
  localparam logic [7:0] OP_INEG      = 8'h74;
  localparam logic [7:0] OP_ISHL      = 8'h78;
  localparam logic [7:0] OP_ISHR      = 8'h7A;
  localparam logic [7:0] OP_IUSHR     = 8'h7C;
  localparam logic [7:0] OP_IAND      = 8'h7E;
  localparam logic [7:0] OP_IOR       = 8'h80;
  localparam logic [7:0] OP_IXOR      = 8'h82;
  localparam logic [7:0] OP_IFEQ      = 8'h99;
  localparam logic [7:0] OP_IFLE      = 8'h9E;
  localparam logic [7:0] OP_IF_ICMPEQ = 8'h9F;
  localparam logic [7:0] OP_IF_ICMPLE = 8'hA4;
  localparam logic [7:0] OP_GOTO      = 8'hA7;

  typedef struct packed {
    aluop_e      aluop;
    logic        isaluop;
    logic        iscmp;
    logic [3:0]  cmptype;
    logic        isargpush;
    logic        isgoto;
    logic [1:0]  argc;
    logic [1:0]  stackargs;
    logic        stackwb;
    logic        constpush;
    logic [31:0] constval;
    logic        illegal;
  } ctrl_t;

endpackage

// File: rtl/alu_decoder_if.sv
// Request/response bundle between the stack-machine control path and
// alu_decoder. The master drives in_valid/op_code/operands and receives the
// registered decode and ALU results; the slave (alu_decoder) is the reverse.
interface alu_decoder_if;
  logic        in_valid;
  logic [7:0]  op_code;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        out_valid;
  logic [3:0]  aluop;
  logic        isaluop;
  logic        iscmp;
  logic [3:0]  cmptype;
  logic        isargpush;
  logic        isgoto;
  logic [1:0]  argc;
  logic [1:0]  stackargs;
  logic        stackwb;
  logic        constpush;
  logic [31:0] constval;
  logic        illegal;
  logic [31:0] result_lo;
  logic [31:0] result_hi;
  logic        cmp_true;

  modport master (
    output in_valid, op_code, operand_a, operand_b,
    input  out_valid, aluop, isaluop, iscmp, cmptype, isargpush, isgoto,
           argc, stackargs, stackwb, constpush, constval, illegal,
           result_lo, result_hi, cmp_true
  );

  modport slave (
    input  in_valid, op_code, operand_a, operand_b,
    output out_valid, aluop, isaluop, iscmp, cmptype, isargpush, isgoto,
           argc, stackargs, stackwb, constpush, constval, illegal,
           result_lo, result_hi, cmp_true
  );
endinterface

// File: rtl/alu_decoder_bc_decoder.sv
// bc_decoder: purely combinational bytecode opcode -> control fields.
// Ports: op_code_i (8-bit opcode), ctrl_o (decoded control struct).
// Build option: ALU_MULDIV_EN enables decode of imul/idiv/irem; without it
// those opcodes fall through to illegal.
module bc_decoder
  import alu_decoder_pkg::*;
(
  input  logic [7:0] op_code_i,
  output ctrl_t      ctrl_o
);

  function automatic ctrl_t alu_fields(input aluop_e op, input logic [1:0] nargs);
    ctrl_t c;
    c           = '0;
    c.aluop     = op;
    c.isaluop   = 1'b1;
    c.stackwb   = 1'b1;
    c.stackargs = nargs;
    return c;
  endfunction

  always_comb begin
    ctrl_o = '0;
    case (op_code_i) inside
      OP_NOP: ctrl_o = '0;
      [OP_ICONST_M1:OP_ICONST_5]: begin
        ctrl_o.constpush = 1'b1;
        ctrl_o.stackwb   = 1'b1;
        // iconst_m1 is 0x02, so op-3 yields -1..5 after 32-bit wrap
        ctrl_o.constval  = {24'd0, op_code_i} - 32'd3;
      end
      OP_BIPUSH: begin
        ctrl_o.isargpush = 1'b1;
        ctrl_o.argc      = 2'd1;
        ctrl_o.stackwb   = 1'b1;
      end
      OP_SIPUSH: begin
        ctrl_o.isargpush = 1'b1;
        ctrl_o.argc      = 2'd2;
        ctrl_o.stackwb   = 1'b1;
      end
      OP_IADD:  ctrl_o = alu_fields(ALU_ADD,  2'd2);
      OP_ISUB:  ctrl_o = alu_fields(ALU_SUB,  2'd2);
`ifdef ALU_MULDIV_EN
      OP_IMUL:  ctrl_o = alu_fields(ALU_MUL,  2'd2);
      OP_IDIV:  ctrl_o = alu_fields(ALU_DIV,  2'd2);
      OP_IREM:  ctrl_o = alu_fields(ALU_REM,  2'd2);
`endif
      OP_INEG:  ctrl_o = alu_fields(ALU_NEG,  2'd1);
      OP_ISHL:  ctrl_o = alu_fields(ALU_SHL,  2'd2);
      OP_ISHR:  ctrl_o = alu_fields(ALU_SHR,  2'd2);
      OP_IUSHR: ctrl_o = alu_fields(ALU_USHR, 2'd2);
      OP_IAND:  ctrl_o = alu_fields(ALU_AND,  2'd2);
      OP_IOR:   ctrl_o = alu_fields(ALU_OR,   2'd2);
      OP_IXOR:  ctrl_o = alu_fields(ALU_XOR,  2'd2);
      [OP_IFEQ:OP_IFLE]: begin
        ctrl_o.iscmp     = 1'b1;
        ctrl_o.argc      = 2'd2;
        ctrl_o.stackargs = 2'd1;
        ctrl_o.cmptype   = {1'b0, 3'(op_code_i - OP_IFEQ)};
      end
      [OP_IF_ICMPEQ:OP_IF_ICMPLE]: begin
        ctrl_o.iscmp     = 1'b1;
        ctrl_o.argc      = 2'd2;
        ctrl_o.stackargs = 2'd2;
        ctrl_o.cmptype   = {1'b1, 3'(op_code_i - OP_IF_ICMPEQ)};
      end
      OP_GOTO: begin
        ctrl_o.isgoto = 1'b1;
        ctrl_o.argc   = 2'd2;
      end
      default: ctrl_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_decoder.sv
// alu_decoder: JVM-subset bytecode decoder plus int32 ALU/comparator with
// one cycle of registered latency.
// Ports: clk, rst (async active-high); bus (alu_decoder_if.slave) carrying
// in_valid/op_code/operand_a/operand_b in and the registered decode fields,
// result_lo/result_hi, cmp_true and out_valid out.
// Build option: ALU_MULDIV_EN adds the multiplier and divider; when it is
// undefined imul/idiv/irem decode illegal and no such hardware exists.
module alu_decoder
  import alu_decoder_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  alu_decoder_if.slave bus
);

  ctrl_t              ctrl_d, ctrl_q;
  logic [31:0]        res_lo_d, res_lo_q;
  logic [31:0]        res_hi_d, res_hi_q;
  logic               cmp_d, cmp_q;
  logic               out_valid_q;
  logic signed [31:0] a_s, b_s, rhs_s;

  bc_decoder u_dec (
    .op_code_i (bus.op_code),
    .ctrl_o    (ctrl_d)
  );

  assign a_s = signed'(bus.operand_a);
  assign b_s = signed'(bus.operand_b);

  // Returns {hi, lo}; hi is only non-zero for the 64-bit product.
  function automatic logic [63:0] alu_eval(input aluop_e op,
                                           input logic signed [31:0] a,
                                           input logic signed [31:0] b);
    logic [31:0] lo;
    logic [31:0] hi;
    lo = 32'd0;
    hi = 32'd0;
    case (op)
      ALU_ADD:  lo = a + b;
      ALU_SUB:  lo = a - b;
`ifdef ALU_MULDIV_EN
      ALU_MUL: begin
        logic signed [63:0] a64;
        logic signed [63:0] b64;
        logic signed [63:0] prod;
        a64  = a;
        b64  = b;
        prod = a64 * b64;
        {hi, lo} = prod;
      end
      // Divide-by-zero and the single overflowing quotient are pinned
      // explicitly rather than left to the divider's native behaviour.
      ALU_DIV: begin
        if (b == 32'sd0)                               lo = 32'd0;
        else if (a == 32'sh8000_0000 && b == -32'sd1)  lo = a;
        else                                           lo = a / b;
      end
      ALU_REM: begin
        if (b == 32'sd0)                               lo = 32'd0;
        else if (a == 32'sh8000_0000 && b == -32'sd1)  lo = 32'd0;
        else                                           lo = a % b;
      end
`endif
      ALU_NEG:  lo = -a;
      ALU_SHL:  lo = a << b[4:0];
      ALU_SHR:  lo = a >>> b[4:0];
      ALU_USHR: lo = $unsigned(a) >> b[4:0];
      ALU_AND:  lo = a & b;
      ALU_OR:   lo = a | b;
      ALU_XOR:  lo = a ^ b;
      default:  lo = 32'd0;
    endcase
    return {hi, lo};
  endfunction

  function automatic logic cmp_eval(input logic [2:0] code,
                                    input logic signed [31:0] a,
                                    input logic signed [31:0] r);
    case (code)
      CMP_EQ:  return a == r;
      CMP_NE:  return a != r;
      CMP_LT:  return a <  r;
      CMP_GE:  return a >= r;
      CMP_GT:  return a >  r;
      CMP_LE:  return a <= r;
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    {res_hi_d, res_lo_d} = 64'd0;
    if (ctrl_d.isaluop) {res_hi_d, res_lo_d} = alu_eval(ctrl_d.aluop, a_s, b_s);
  end

  // cmptype[3] selects compare-with-value2 versus compare-with-zero
  assign rhs_s = ctrl_d.cmptype[3] ? b_s : 32'sd0;
  assign cmp_d = ctrl_d.iscmp & cmp_eval(ctrl_d.cmptype[2:0], a_s, rhs_s);

  // Output register stage: captured on in_valid, held otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      ctrl_q      <= '0;
      res_lo_q    <= 32'd0;
      res_hi_q    <= 32'd0;
      cmp_q       <= 1'b0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        ctrl_q   <= ctrl_d;
        res_lo_q <= res_lo_d;
        res_hi_q <= res_hi_d;
        cmp_q    <= cmp_d;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.aluop     = ctrl_q.aluop;
  assign bus.isaluop   = ctrl_q.isaluop;
  assign bus.iscmp     = ctrl_q.iscmp;
  assign bus.cmptype   = ctrl_q.cmptype;
  assign bus.isargpush = ctrl_q.isargpush;
  assign bus.isgoto    = ctrl_q.isgoto;
  assign bus.argc      = ctrl_q.argc;
  assign bus.stackargs = ctrl_q.stackargs;
  assign bus.stackwb   = ctrl_q.stackwb;
  assign bus.constpush = ctrl_q.constpush;
  assign bus.constval  = ctrl_q.constval;
  assign bus.illegal   = ctrl_q.illegal;
  assign bus.result_lo = res_lo_q;
  assign bus.result_hi = res_hi_q;
  assign bus.cmp_true  = cmp_q;

endmodule

// File: tb/tb_alu_decoder.sv
// Scoreboard bench for alu_decoder: stimulus pushes model predictions into a
// queue tagged with the cycle they are due; a monitor on the falling edge
// pops and compares, and checks idle/hold behaviour in between.
module tb_alu_decoder;

`ifdef ALU_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_decoder_if bus ();

  alu_decoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          due;
    logic [7:0]  op;
    logic [3:0]  aluop;
    logic        isaluop;
    logic        iscmp;
    logic [3:0]  cmptype;
    logic        isargpush;
    logic        isgoto;
    logic [1:0]  argc;
    logic [1:0]  stackargs;
    logic        stackwb;
    logic        constpush;
    logic [31:0] constval;
    logic        illegal;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        cmp;
  } exp_t;

  exp_t q[$];
  exp_t last;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: the opcode table and Java int semantics, evaluated
  // with 64-bit integer arithmetic and then wrapped to 32 bits.
  function automatic exp_t model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t       e;
    longint     sa, sb, ua, r, rhs;
    int         sh, idx, k, code;
    bit         two;
    logic [7:0] alu_ops [12];
    alu_ops = '{8'h60, 8'h64, 8'h68, 8'h6C, 8'h70, 8'h74,
                8'h78, 8'h7A, 8'h7C, 8'h7E, 8'h80, 8'h82};
    e   = '{default: 0};
    e.op = op;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'd0, a});
    sh  = int'(b[4:0]);
    r   = 0;
    idx = -1;
    for (int i = 0; i < 12; i++) if (alu_ops[i] == op) idx = i;
    if (op == 8'h00) begin
      e.illegal = 1'b0;
    end else if (op >= 8'h02 && op <= 8'h08) begin
      e.constpush = 1'b1;
      e.stackwb   = 1'b1;
      e.constval  = 32'(int'(op) - 3);
    end else if (op == 8'h10 || op == 8'h11) begin
      e.isargpush = 1'b1;
      e.stackwb   = 1'b1;
      e.argc      = (op == 8'h10) ? 2'd1 : 2'd2;
    end else if (idx >= 0 && (MD || idx < 2 || idx > 4)) begin
      e.isaluop   = 1'b1;
      e.stackwb   = 1'b1;
      e.stackargs = (idx == 5) ? 2'd1 : 2'd2;
      e.aluop     = 4'(idx);
      case (idx)
        0:  r = sa + sb;
        1:  r = sa - sb;
        2:  r = sa * sb;
        3:  r = (sb == 0) ? 0 : sa / sb;
        4:  r = (sb == 0) ? 0 : sa - (sa / sb) * sb;
        5:  r = -sa;
        6:  r = ua << sh;
        7:  r = sa >>> sh;
        8:  r = ua >> sh;
        9:  r = sa & sb;
        10: r = sa | sb;
        default: r = sa ^ sb;
      endcase
      e.lo = r[31:0];
      e.hi = (idx == 2) ? r[63:32] : 32'd0;
    end else if (op >= 8'h99 && op <= 8'hA4) begin
      k    = int'(op) - 'h99;
      two  = (k >= 6);
      code = k % 6;
      rhs  = two ? sb : 0;
      e.iscmp     = 1'b1;
      e.argc      = 2'd2;
      e.stackargs = two ? 2'd2 : 2'd1;
      e.cmptype   = {two, 3'(code)};
      case (code)
        0: e.cmp = (sa == rhs);
        1: e.cmp = (sa != rhs);
        2: e.cmp = (sa <  rhs);
        3: e.cmp = (sa >= rhs);
        4: e.cmp = (sa >  rhs);
        default: e.cmp = (sa <= rhs);
      endcase
    end else if (op == 8'hA7) begin
      e.isgoto = 1'b1;
      e.argc   = 2'd2;
    end else begin
      e.illegal = 1'b1;
    end
    return e;
  endfunction

  task automatic compare_all(input exp_t e);
    string p;
    p = $sformatf("op%02h_", e.op);
    chk({p, "aluop"},     bus.aluop,     e.aluop);
    chk({p, "isaluop"},   bus.isaluop,   e.isaluop);
    chk({p, "iscmp"},     bus.iscmp,     e.iscmp);
    chk({p, "cmptype"},   bus.cmptype,   e.cmptype);
    chk({p, "isargpush"}, bus.isargpush, e.isargpush);
    chk({p, "isgoto"},    bus.isgoto,    e.isgoto);
    chk({p, "argc"},      bus.argc,      e.argc);
    chk({p, "stackargs"}, bus.stackargs, e.stackargs);
    chk({p, "stackwb"},   bus.stackwb,   e.stackwb);
    chk({p, "constpush"}, bus.constpush, e.constpush);
    chk({p, "constval"},  bus.constval,  e.constval);
    chk({p, "illegal"},   bus.illegal,   e.illegal);
    chk({p, "result_lo"}, bus.result_lo, e.lo);
    chk({p, "result_hi"}, bus.result_hi, e.hi);
    chk({p, "cmp_true"},  bus.cmp_true,  e.cmp);
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_out_valid"}, bus.out_valid, 0);
    chk({nm, "_ctrl"}, {bus.aluop, bus.isaluop, bus.iscmp, bus.cmptype, bus.isargpush,
                        bus.isgoto, bus.argc, bus.stackargs, bus.stackwb, bus.constpush,
                        bus.illegal, bus.cmp_true}, 0);
    chk({nm, "_constval"}, bus.constval, 0);
    chk({nm, "_result_lo"}, bus.result_lo, 0);
    chk({nm, "_result_hi"}, bus.result_hi, 0);
  endtask

  // Monitor: compares on the falling edge, away from the capturing edge
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        if (q.size() > 0 && q[0].due <= cyc) begin
          e = q.pop_front();
          chk($sformatf("op%02h_out_valid", e.op), bus.out_valid, 1);
          if (bus.out_valid === 1'b1) compare_all(e);
          last = e;
        end else begin
          chk("out_valid_idle", bus.out_valid, 0);
          chk("hold_result_lo", bus.result_lo, last.lo);
          chk("hold_ctrl", {bus.illegal, bus.stackwb, bus.argc, bus.cmp_true},
                           {last.illegal, last.stackwb, last.argc, last.cmp});
        end
      end
    end
  end

  // Drive at posedge+1; DUT captures on the next posedge
  task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e     = model(op, a, b);
    e.due = cyc + 1;
    q.push_back(e);
    bus.in_valid  = 1'b1;
    bus.op_code   = op;
    bus.operand_a = a;
    bus.operand_b = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  logic [7:0] op_pool [24];

  initial begin : stim
    logic [7:0] op;
    op_pool = '{8'h00, 8'h02, 8'h05, 8'h08, 8'h10, 8'h11, 8'h60, 8'h64,
                8'h68, 8'h6C, 8'h70, 8'h74, 8'h78, 8'h7A, 8'h7C, 8'h7E,
                8'h80, 8'h82, 8'h99, 8'h9C, 8'h9E, 8'h9F, 8'hA3, 8'hA7};
    last          = '{default: 0};
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op_code   = 8'h00;
    bus.operand_a = 32'd0;
    bus.operand_b = 32'd0;
    #12;
    check_zero("reset");
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    issue(8'h02, 32'd0, 32'd0);
    issue(8'h11, 32'd0, 32'd0);
    issue(8'hA7, 32'd0, 32'd0);
    issue(8'h60, 32'h7FFF_FFFF, 32'd1);
    issue(8'h6C, 32'hFFFF_FFF9, 32'd2);
    issue(8'h70, 32'hFFFF_FFF9, 32'd2);
    issue(8'h6C, 32'd5, 32'd0);
    issue(8'h70, 32'd5, 32'd0);
    issue(8'h6C, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(8'h70, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(8'h68, 32'h8000_0000, 32'h8000_0000);
    issue(8'h68, 32'hFFFF_FFFD, 32'd7);
    issue(8'h9B, 32'hFFFF_FFFF, 32'd0);
    issue(8'hA3, 32'd3, 32'd5);
    issue(8'hFF, 32'd1, 32'd2);
    issue(8'h00, 32'd9, 32'd9);
    issue(8'h74, 32'h8000_0000, 32'd0);
    issue(8'h7A, 32'h8000_0000, 32'd33);
    issue(8'h7C, 32'h8000_0000, 32'd31);
    issue(8'h78, 32'h0000_0003, 32'd30);
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a request
    @(negedge clk);
    #2;
    bus.in_valid = 1'b1;
    bus.op_code  = 8'h60;
    rst          = 1'b1;
    last         = '{default: 0};
    #1;
    check_zero("rst_async");
    @(posedge clk);
    #1;
    chk("rst_edge_out_valid", bus.out_valid, 0);
    bus.in_valid = 1'b0;
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    for (int n = 0; n < 400; n++) begin
      op = ($urandom_range(0, 5) == 0) ? 8'($urandom()) : op_pool[$urandom_range(0, 23)];
      issue(op, pick_operand(), pick_operand());
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
